// File: rtl/pps_divider.sv
// One PPS divider channel: divides the synchronized PPS by N and emits a
// pulse delayed by phase_us and lasting width_us, single shot or continuous.
module pps_divider #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_PER_US = 10
) (
    input  logic                      i_clk_10,
    input  logic                      i_rst,
    input  logic                      i_pps,
    input  logic [DATA_WIDTH-1:0]     i_periodic_true,
    input  logic [DATA_WIDTH-1:0]     i_div_number,
    input  logic [DATA_WIDTH*3-1:0]   i_phase_us,
    input  logic [DATA_WIDTH-1:0]     i_width_us,
    input  logic [DATA_WIDTH-1:0]     i_start,
    input  logic [DATA_WIDTH-1:0]     i_stop,
    output logic                      o_pulse,
    output logic                      o_armed,
    output logic [1:0]                o_state
);

    localparam int PHASE_W = DATA_WIDTH * 3;
    localparam int PRE_W   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PRE_W-1:0]      PRE_MAX   = PRE_W'(CLK_PER_US - 1);
    localparam logic [PHASE_W-1:0]    PHASE_ONE = PHASE_W'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ONE  = DATA_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_PPS = 2'd1,
        PHASE    = 2'd2,
        HIGH     = 2'd3
    } state_t;

    state_t state;
    state_t next_state;
    state_t end_state;

    logic                  pps_meta;
    logic                  pps_sync;
    logic                  pps_prev;
    logic                  pps_tick;
    logic                  start_prev;
    logic                  start_tick;
    logic [1:0]            settle_cnt;

    logic [DATA_WIDTH-1:0] pps_cnt;
    logic [DATA_WIDTH-1:0] div_eff;
    logic                  pps_fire;

    logic [PRE_W-1:0]      prescale;
    logic                  us_tick;
    logic                  restart_us;

    logic [PHASE_W-1:0]    phase_cnt;
    logic [DATA_WIDTH-1:0] width_cnt;

    logic                  load_cfg;
    logic                  dec_phase;
    logic                  dec_width;
    logic                  arm;

    logic                  unused_cfg_bits;
    assign unused_cfg_bits = ^{i_periodic_true[DATA_WIDTH-1:1],
                               i_start[DATA_WIDTH-1:1],
                               i_stop[DATA_WIDTH-1:1]};

    // Edge detectors stay quiet until the chains hold real samples, so a
    // level already high at reset release never looks like a new edge.
    always_ff @(posedge i_clk_10 or posedge i_rst) begin
        if (i_rst) begin
            settle_cnt <= 2'd0;
        end else if (settle_cnt != 2'd3) begin
            settle_cnt <= settle_cnt + 2'd1;
        end
    end

    always_ff @(posedge i_clk_10 or posedge i_rst) begin
        if (i_rst) begin
            pps_meta   <= 1'b0;
            pps_sync   <= 1'b0;
            pps_prev   <= 1'b0;
            pps_tick   <= 1'b0;
            start_prev <= 1'b0;
            start_tick <= 1'b0;
        end else begin
            pps_meta   <= i_pps;
            pps_sync   <= pps_meta;
            pps_prev   <= pps_sync;
            pps_tick   <= (settle_cnt == 2'd3) && pps_sync && !pps_prev;
            start_prev <= i_start[0];
            start_tick <= (settle_cnt != 2'd0) && i_start[0] && !start_prev;
        end
    end

    assign div_eff  = (i_div_number == '0) ? DATA_ONE : i_div_number;
    assign pps_fire = pps_tick && (pps_cnt == '0);

    // Wrap only on an exact match so a live reduction of N below the current
    // count rolls through the counter maximum before the new N takes hold.
    always_ff @(posedge i_clk_10 or posedge i_rst) begin
        if (i_rst) begin
            pps_cnt <= '0;
        end else if (arm) begin
            pps_cnt <= '0;
        end else if ((state != IDLE) && pps_tick) begin
            if (pps_cnt == (div_eff - DATA_ONE)) begin
                pps_cnt <= '0;
            end else begin
                pps_cnt <= pps_cnt + DATA_ONE;
            end
        end
    end

    assign us_tick    = (prescale == PRE_MAX);
    assign restart_us = ((next_state == PHASE) && (state != PHASE)) ||
                        ((next_state == HIGH)  && (state != HIGH));

    always_ff @(posedge i_clk_10 or posedge i_rst) begin
        if (i_rst) begin
            prescale <= '0;
        end else if (restart_us || us_tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + PRE_W'(1);
        end
    end

    always_ff @(posedge i_clk_10 or posedge i_rst) begin
        if (i_rst) begin
            phase_cnt <= '0;
            width_cnt <= '0;
        end else if (load_cfg) begin
            phase_cnt <= i_phase_us;
            width_cnt <= i_width_us;
        end else begin
            if (dec_phase) begin
                phase_cnt <= phase_cnt - PHASE_ONE;
            end
            if (dec_width) begin
                width_cnt <= width_cnt - DATA_ONE;
            end
        end
    end

    assign end_state = i_periodic_true[0] ? WAIT_PPS : IDLE;

    always_comb begin
        next_state = state;
        load_cfg   = 1'b0;
        dec_phase  = 1'b0;
        dec_width  = 1'b0;
        arm        = 1'b0;
        if (i_stop[0]) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_tick) begin
                        next_state = WAIT_PPS;
                        arm        = 1'b1;
                    end
                end
                WAIT_PPS: begin
                    if (pps_fire) begin
                        load_cfg = 1'b1;
                        if (i_phase_us != '0) begin
                            next_state = PHASE;
                        end else if (i_width_us != '0) begin
                            next_state = HIGH;
                        end else begin
                            next_state = end_state;
                        end
                    end
                end
                PHASE: begin
                    if (us_tick) begin
                        dec_phase = 1'b1;
                        if (phase_cnt <= PHASE_ONE) begin
                            next_state = (width_cnt != '0) ? HIGH : end_state;
                        end
                    end
                end
                HIGH: begin
                    if (us_tick) begin
                        dec_width = 1'b1;
                        if (width_cnt <= DATA_ONE) begin
                            next_state = end_state;
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk_10 or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            o_pulse <= 1'b0;
        end else begin
            state   <= next_state;
            o_pulse <= (next_state == HIGH);
        end
    end

    assign o_armed = (state != IDLE);
    assign o_state = state;

endmodule

// File: tb/tb_pps_divider.sv
// Scoreboard bench for pps_divider: each firing PPS pushes its expected pulse
// (rise edge, high cycles); a negedge monitor pops and compares every pulse.
`timescale 1ns/1ps
module tb_pps_divider;

    localparam int DW  = 8;
    localparam int CPU = 10;

    logic            i_clk_10 = 1'b0;
    logic            i_rst    = 1'b1;
    logic            i_pps    = 1'b0;
    logic [DW-1:0]   i_periodic_true = '0;
    logic [DW-1:0]   i_div_number    = '0;
    logic [DW*3-1:0] i_phase_us      = '0;
    logic [DW-1:0]   i_width_us      = '0;
    logic [DW-1:0]   i_start         = '0;
    logic [DW-1:0]   i_stop          = '0;
    logic            o_pulse;
    logic            o_armed;
    logic [1:0]      o_state;

    typedef struct {
        int rise;
        int width;
    } exp_t;

    exp_t sb[$];
    int   cyc             = 0;
    int   vectors         = 0;
    int   miscompares     = 0;
    int   pulses_seen     = 0;
    int   pulses_expected = 0;
    int   rise_cyc        = 0;
    logic pulse_prev      = 1'b0;

    pps_divider #(.DATA_WIDTH(DW), .CLK_PER_US(CPU)) dut (
        .i_clk_10        (i_clk_10),
        .i_rst           (i_rst),
        .i_pps           (i_pps),
        .i_periodic_true (i_periodic_true),
        .i_div_number    (i_div_number),
        .i_phase_us      (i_phase_us),
        .i_width_us      (i_width_us),
        .i_start         (i_start),
        .i_stop          (i_stop),
        .o_pulse         (o_pulse),
        .o_armed         (o_armed),
        .o_state         (o_state)
    );

    always #50 i_clk_10 = ~i_clk_10;

    always @(posedge i_clk_10) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Monitor: edge numbers are the cycle counter value after each posedge.
    always @(negedge i_clk_10) begin
        exp_t e;
        if (o_pulse && !pulse_prev) begin
            rise_cyc = cyc;
            pulses_seen++;
        end
        if (!o_pulse && pulse_prev && (sb.size() > 0)) begin
            e = sb.pop_front();
            checkOutput("rise_edge", rise_cyc, e.rise);
            checkOutput("high_cycles", cyc - rise_cyc, e.width);
        end
        pulse_prev = o_pulse;
    end

    task automatic waitCycle(input int target);
        while (cyc < target) @(negedge i_clk_10);
    endtask

    task automatic pushExpected(input int rise, input int width);
        sb.push_back('{rise: rise, width: width});
        pulses_expected++;
    endtask

    task automatic applyStimulus(input logic periodic, input int div,
                                 input int phase, input int width);
        i_periodic_true = DW'(periodic);
        i_div_number    = DW'(div);
        i_phase_us      = (DW*3)'(phase);
        i_width_us      = DW'(width);
    endtask

    task automatic armChannel();
        @(negedge i_clk_10);
        i_start = 8'h01;
        @(negedge i_clk_10);
        checkOutput("arm_lat1", o_armed, 0);
        @(negedge i_clk_10);
        checkOutput("arm_lat2", o_armed, 1);
        i_start = '0;
    endtask

    task automatic pulsePps(input bit fire, input int phase, input int width,
                            output int edge0);
        @(negedge i_clk_10);
        i_pps = 1'b1;
        edge0 = cyc + 1;
        if (fire) pushExpected(edge0 + 3 + phase * CPU, width * CPU);
        repeat (4) @(negedge i_clk_10);
        i_pps = 1'b0;
    endtask

    task automatic stopChannel();
        @(negedge i_clk_10);
        i_stop = 8'h01;
        @(negedge i_clk_10);
        checkOutput("stop_state", o_state, 0);
        checkOutput("stop_pulse", o_pulse, 0);
        i_stop = '0;
    endtask

    initial begin
        int e;
        int e2;

        // Reset state
        repeat (3) @(negedge i_clk_10);
        checkOutput("rst_pulse", o_pulse, 0);
        checkOutput("rst_armed", o_armed, 0);
        checkOutput("rst_state", o_state, 0);
        i_rst = 1'b0;
        repeat (6) @(negedge i_clk_10);

        // Basic single shot
        $display("[TB] single shot");
        applyStimulus(1'b0, 1, 0, 5);
        armChannel();
        pulsePps(1'b1, 0, 5, e);
        waitCycle(e + 80);
        checkOutput("ss_state", o_state, 0);
        checkOutput("ss_armed", o_armed, 0);
        pulsePps(1'b0, 0, 5, e);
        waitCycle(e + 80);
        checkOutput("ss_count", pulses_seen, pulses_expected);

        // Continuous divide-by-3
        $display("[TB] divide by 3");
        applyStimulus(1'b1, 3, 2, 1);
        armChannel();
        for (int i = 0; i < 7; i++) begin
            pulsePps((i % 3) == 0, 2, 1, e);
            waitCycle(e + 40);
        end
        checkOutput("div3_count", pulses_seen, pulses_expected);
        checkOutput("div3_state", o_state, 1);
        stopChannel();

        // 24-bit phase, live change of phase and mode during PHASE
        $display("[TB] wide phase");
        applyStimulus(1'b1, 1, 32'h000100, 3);
        armChannel();
        pulsePps(1'b1, 32'h100, 3, e);
        waitCycle(e + 100);
        checkOutput("wp_in_phase", o_state, 2);
        i_phase_us = 24'h000003;
        waitCycle(e + 2620);
        pulsePps(1'b1, 3, 3, e2);
        waitCycle(e2 + 10);
        i_periodic_true = '0;
        waitCycle(e2 + 80);
        checkOutput("wp_count", pulses_seen, pulses_expected);
        checkOutput("wp_end_idle", o_state, 0);

        // Stop mid-HIGH
        $display("[TB] stop and start priority");
        applyStimulus(1'b1, 1, 0, 20);
        armChannel();
        pulsePps(1'b0, 0, 20, e);
        pushExpected(e + 3, 10);
        waitCycle(e + 12);
        checkOutput("mid_high", o_pulse, 1);
        i_stop = 8'h01;
        @(negedge i_clk_10);
        checkOutput("stop_hi_pulse", o_pulse, 0);
        checkOutput("stop_hi_state", o_state, 0);
        i_stop = '0;
        repeat (3) @(negedge i_clk_10);

        // Start and stop rising together
        i_start = 8'h01;
        i_stop  = 8'h01;
        repeat (4) @(negedge i_clk_10);
        checkOutput("ss_prio_armed", o_armed, 0);
        i_stop = '0;
        repeat (4) @(negedge i_clk_10);
        checkOutput("ss_prio_state", o_state, 0);
        i_start = '0;
        repeat (2) @(negedge i_clk_10);

        // Divide number 0 fires on every PPS
        applyStimulus(1'b1, 0, 0, 1);
        armChannel();
        for (int i = 0; i < 3; i++) begin
            pulsePps(1'b1, 0, 1, e);
            waitCycle(e + 30);
        end
        checkOutput("div0_count", pulses_seen, pulses_expected);
        stopChannel();

        // Overlap: PPS during PHASE is ignored, then zero width
        $display("[TB] overlap");
        applyStimulus(1'b1, 1, 500, 10);
        armChannel();
        pulsePps(1'b1, 500, 10, e);
        waitCycle(e + 2000);
        pulsePps(1'b0, 500, 10, e2);
        waitCycle(e + 2100);
        checkOutput("ovl_phase", o_state, 2);
        waitCycle(e + 5200);
        checkOutput("ovl_wait", o_state, 1);
        checkOutput("ovl_count", pulses_seen, pulses_expected);
        applyStimulus(1'b1, 1, 0, 0);
        pulsePps(1'b0, 0, 0, e);
        waitCycle(e + 40);
        checkOutput("w0_state", o_state, 1);
        checkOutput("w0_count", pulses_seen, pulses_expected);
        stopChannel();

        // Async reset mid-PHASE with PPS held high through release
        $display("[TB] async reset");
        applyStimulus(1'b1, 1, 10, 2);
        armChannel();
        @(negedge i_clk_10);
        i_pps = 1'b1;
        e = cyc + 1;
        waitCycle(e + 50);
        checkOutput("ar_phase", o_state, 2);
        #20 i_rst = 1'b1;
        #1;
        checkOutput("ar_pulse", o_pulse, 0);
        checkOutput("ar_armed", o_armed, 0);
        checkOutput("ar_state", o_state, 0);
        @(negedge i_clk_10);
        i_rst = 1'b0;
        repeat (10) @(negedge i_clk_10);
        armChannel();
        repeat (100) @(negedge i_clk_10);
        checkOutput("ar_no_fire", o_state, 1);
        checkOutput("ar_count", pulses_seen, pulses_expected);
        i_pps = 1'b0;
        repeat (5) @(negedge i_clk_10);
        pulsePps(1'b1, 10, 2, e);
        waitCycle(e + 150);
        checkOutput("final_count", pulses_seen, pulses_expected);
        checkOutput("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
